rom_port_arbiter: RTL and testbench

Shares the single combinational-read program ROM (WIDTH x 2^ADDR_WIDTH words) between two requesters: the instruction-fetch unit (IF) and a data-side reader (DM) for constant-table loads out of program memory. It arbitrates between the two, drives the ROM address, and registers the read word. It returns the word to the winner through a valid/ready handshake. It sits between the multicycle control/datapath and the `rom` instance, and is the only driver of the ROM address.

---
 rtl/rom_arb_pkg.sv | 11 +
 rtl/rom_arb_pick.sv | 26 ++
 rtl/rom_port_arbiter.sv | 90 +++++++++
 tb/tb_rom_port_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared types and constants for the program-ROM port arbiter.
//   arb_state_t : arbiter FSM state (ARB_IDLE, ARB_RESP)
//   REQ_IF/DM   : requester indices used for grant and pick encoding
package rom_arb_pkg;
   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_RESP = 1'b1
   } arb_state_t;
   localparam logic REQ_IF = 1'b0;
   localparam logic REQ_DM = 1'b1;
endpackage

// File: rtl/rom_arb_pick.sv
// rom_arb_pick: combinational winner-select between the IF and DM requesters.
// Policy macro ROM_ARB_RR_EN: defined = round-robin on i_last_grant, else IF has fixed priority.
//   i_if_req, i_dm_req : request levels
//   i_last_grant       : last granted requester (round-robin build only)
//   o_pick_valid       : at least one request present
//   o_pick_idx         : winner index; REQ_IF when no request
module rom_arb_pick
   import rom_arb_pkg::*;
(
   input  logic i_if_req,
   input  logic i_dm_req,
`ifdef ROM_ARB_RR_EN
   input  logic i_last_grant,
`endif
   output logic o_pick_valid,
   output logic o_pick_idx
);
   always_comb begin
      o_pick_valid = i_if_req | i_dm_req;
`ifdef ROM_ARB_RR_EN
      o_pick_idx   = (i_if_req & i_dm_req) ? ~i_last_grant : (i_dm_req ? REQ_DM : REQ_IF);
`else
      o_pick_idx   = i_if_req ? REQ_IF : (i_dm_req ? REQ_DM : REQ_IF);
`endif
   end
endmodule

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one combinational program ROM between instruction fetch and a data reader.
// Macro ROM_ARB_RR_EN selects round-robin arbitration; default is fixed IF-over-DM priority.
//   i_clk, i_reset            : clock, synchronous active-high reset
//   i_if_req/addr/rready      : fetch request, word address, result accept
//   o_if_rvalid               : fetch result valid on o_rdata
//   i_dm_req/addr/rready      : data-reader request, word address, result accept
//   o_dm_rvalid               : data-reader result valid on o_rdata
//   o_rdata                   : registered read word shared by both requesters
//   o_rom_addr, i_rom_data    : ROM address out, combinational ROM word in
//   o_busy                    : high while a response is outstanding
module rom_port_arbiter
   import rom_arb_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_if_req,
   input  logic [ADDR_WIDTH-1:0] i_if_addr,
   output logic                  o_if_rvalid,
   input  logic                  i_if_rready,
   input  logic                  i_dm_req,
   input  logic [ADDR_WIDTH-1:0] i_dm_addr,
   output logic                  o_dm_rvalid,
   input  logic                  i_dm_rready,
   output logic [WIDTH-1:0]      o_rdata,
   output logic [ADDR_WIDTH-1:0] o_rom_addr,
   input  logic [WIDTH-1:0]      i_rom_data,
   output logic                  o_busy
);
   arb_state_t            r_state;
   logic                  r_grant;
   logic [ADDR_WIDTH-1:0] r_gaddr;
   logic [WIDTH-1:0]      r_rdata;
   logic                  r_if_rvalid;
   logic                  r_dm_rvalid;
   logic                  r_busy;
   logic                  w_pick_valid;
   logic                  w_pick_idx;
   logic [ADDR_WIDTH-1:0] w_pick_addr;
   logic                  w_rready;

   // r_grant doubles as the round-robin history; it resets to DM so IF wins the first tie
   rom_arb_pick u_pick (
      .i_if_req     (i_if_req),
      .i_dm_req     (i_dm_req),
`ifdef ROM_ARB_RR_EN
      .i_last_grant (r_grant),
`endif
      .o_pick_valid (w_pick_valid),
      .o_pick_idx   (w_pick_idx)
   );

   assign w_pick_addr = (w_pick_idx == REQ_DM) ? i_dm_addr : i_if_addr;
   assign w_rready    = (r_grant == REQ_DM) ? i_dm_rready : i_if_rready;
   // the latched grant address keeps the ROM output stable while the response is held
   assign o_rom_addr  = (r_state == ARB_RESP) ? r_gaddr : w_pick_addr;
   assign o_rdata     = r_rdata;
   assign o_if_rvalid = r_if_rvalid;
   assign o_dm_rvalid = r_dm_rvalid;
   assign o_busy      = r_busy;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= ARB_IDLE;
         r_grant     <= REQ_DM;
         r_gaddr     <= '0;
         r_rdata     <= '0;
         r_if_rvalid <= 1'b0;
         r_dm_rvalid <= 1'b0;
         r_busy      <= 1'b0;
      end else if (r_state == ARB_IDLE) begin
         if (w_pick_valid) begin
            r_state     <= ARB_RESP;
            r_grant     <= w_pick_idx;
            r_gaddr     <= w_pick_addr;
            r_rdata     <= i_rom_data;
            r_if_rvalid <= (w_pick_idx == REQ_IF);
            r_dm_rvalid <= (w_pick_idx == REQ_DM);
            r_busy      <= 1'b1;
         end
      end else if (w_rready) begin
         r_state     <= ARB_IDLE;
         r_if_rvalid <= 1'b0;
         r_dm_rvalid <= 1'b0;
         r_busy      <= 1'b0;
      end
   end
endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: scoreboard bench for rom_port_arbiter with directed and random requesters.
module tb_rom_port_arbiter;
`ifdef ROM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   typedef struct {
      bit          idx;
      logic [9:0]  addr;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        if_req, dm_req, if_rready, dm_rready;
   logic [9:0]  if_addr, dm_addr, rom_addr;
   logic        if_rvalid, dm_rvalid, busy;
   logic [31:0] rdata, rom_data;
   logic [31:0] rom_mem [1024];

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t exp_q[$];
   bit   grants[$];
   bit   m_busy = 0, m_who = 1, m_last = 1, m_rst = 0;
   bit   hs_if, hs_dm;

   rom_port_arbiter #(.WIDTH(32), .ADDR_WIDTH(10)) dut (
      .i_clk(clk), .i_reset(reset),
      .i_if_req(if_req), .i_if_addr(if_addr), .o_if_rvalid(if_rvalid), .i_if_rready(if_rready),
      .i_dm_req(dm_req), .i_dm_addr(dm_addr), .o_dm_rvalid(dm_rvalid), .i_dm_rready(dm_rready),
      .o_rdata(rdata), .o_rom_addr(rom_addr), .i_rom_data(rom_data), .o_busy(busy)
   );

   assign rom_data = rom_mem[rom_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", n, act, exp, $time);
      end
   endtask

   task automatic timeout(input string n);
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=handshake t=%0t", n, $time);
   endtask

   // reference model: one outstanding read; ties go to IF or, in round-robin, to the one not served last
   always @(posedge clk) begin
      bit w;
      logic [9:0] a;
      cyc++;
      m_rst = reset;
      if (reset) begin
         m_busy = 0;
         m_who  = 1;
         m_last = 1;
         exp_q.delete();
      end else if (!m_busy) begin
         if (if_req || dm_req) begin
            w = (if_req && dm_req) ? (RR ? !m_last : 1'b0) : dm_req;
            a = w ? dm_addr : if_addr;
            exp_q.push_back('{idx: w, addr: a, data: rom_mem[a], cyc: cyc});
            m_busy = 1;
            m_who  = w;
            m_last = w;
         end
      end else if (m_who ? dm_rready : if_rready) begin
         m_busy = 0;
      end
   end

   // monitor: pops an expectation whenever a response appears, checks it stays put while held
   bit          pv = 0;
   logic [31:0] hold = 0;
   logic [9:0]  haddr = 0;
   always @(negedge clk) begin
      bit v;
      exp_t e;
      v = if_rvalid | dm_rvalid;
      chk("valid_busy", {if_rvalid, dm_rvalid, busy}, {m_busy & ~m_who, m_busy & m_who, m_busy});
      if (m_rst) begin
         hold = 0;
         chk("rdata_reset", rdata, 0);
      end else if (v && !pv) begin
         if (exp_q.size() == 0) begin
            timeout("unexpected_resp");
         end else begin
            e = exp_q.pop_front();
            chk("grant_idx", dm_rvalid, e.idx);
            chk("rdata", rdata, e.data);
            chk("latency_cyc", cyc, e.cyc);
            chk("rom_addr", rom_addr, e.addr);
            hold  = e.data;
            haddr = e.addr;
            grants.push_back(dm_rvalid);
         end
      end else begin
         chk("rdata_hold", rdata, hold);
         if (v) chk("rom_addr_hold", rom_addr, haddr);
      end
      pv = v;
   end

   // advances one clock; hs_* report a handshake taken at that edge
   task automatic tick();
      @(negedge clk);
      #1;
      hs_if = if_rvalid & if_rready;
      hs_dm = dm_rvalid & dm_rready;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_hs(input bit dm, input string n);
      for (int k = 0; k < 40; k++) begin
         tick();
         if (!dm && hs_if) begin if_req = 0; return; end
         if (dm && hs_dm) begin dm_req = 0; return; end
      end
      timeout(n);
   endtask

   task automatic do_reset();
      reset = 1;
      tick();
      tick();
      reset = 0;
      tick();
   endtask

   initial begin
      int g0;
      logic [9:0] a;
      for (int i = 0; i < 1024; i++) rom_mem[i] = $urandom;
      rom_mem[10'h004] = 32'h8C010010;
      rom_mem[10'h3FF] = 32'hDEADBEEF;
      {if_req, dm_req, if_rready, dm_rready} = '0;
      if_addr = '0;
      dm_addr = '0;
      reset = 1;
      tick();
      tick();
      chk("reset_valid_busy", {if_rvalid, dm_rvalid, busy}, 0);
      chk("reset_rdata", rdata, 0);
      reset = 0;
      tick();
      // IF only, one-cycle latency
      if_req = 1; if_addr = 10'h004; if_rready = 1;
      tick();
      chk("if_only_valid", if_rvalid, 1);
      chk("if_only_rdata", rdata, 32'h8C010010);
      tick();
      if_req = 0;
      chk("if_only_idle", busy, 0);
      tick();
      // DM backpressure for five cycles
      dm_req = 1; dm_addr = 10'h3FF; dm_rready = 0;
      tick();
      for (int k = 0; k < 5; k++) begin
         chk("bp_valid", dm_rvalid, 1);
         chk("bp_rdata", rdata, 32'hDEADBEEF);
         tick();
      end
      chk("bp_valid6", dm_rvalid, 1);
      dm_rready = 1;
      tick();
      dm_req = 0;
      chk("bp_done", dm_rvalid, 0);
      tick();
      // simultaneous held requests, policy sequence from a fresh reset
      do_reset();
      g0 = grants.size();
      if_req = 1; if_addr = 10'h010; if_rready = 1;
      dm_req = 1; dm_addr = 10'h020; dm_rready = 1;
      for (int n = 0; n < 60 && grants.size() < g0 + 8; n++) tick();
      chk("policy_count", grants.size() >= g0 + 8, 1);
      for (int k = 0; k < 8; k++) chk("policy_seq", grants[g0 + k], RR ? (k % 2) : 0);
      wait_hs(0, "sim_if_drain");
      wait_hs(1, "sim_dm_drain");
      tick();
      // DM request ignored while IF response is held
      if_req = 1; if_addr = 10'h155; if_rready = 0;
      tick();
      dm_req = 1; dm_addr = 10'h2AA; dm_rready = 1;
      tick();
      if_rready = 1;
      tick();
      if_req = 0;
      chk("ignore_no_dm", dm_rvalid, 0);
      tick();
      chk("ignore_dm_valid", dm_rvalid, 1);
      chk("ignore_dm_rdata", rdata, rom_mem[10'h2AA]);
      tick();
      dm_req = 0;
      tick();
      // reset while a response is held, then reissue
      a = 10'h0F0;
      if_req = 1; if_addr = a; if_rready = 0;
      tick();
      chk("rst_pre_valid", if_rvalid, 1);
      reset = 1;
      tick();
      chk("rst_valids", {if_rvalid, dm_rvalid}, 0);
      chk("rst_rdata", rdata, 0);
      reset = 0;
      if_rready = 1;
      tick();
      chk("reissue_valid", if_rvalid, 1);
      chk("reissue_rdata", rdata, rom_mem[a]);
      tick();
      if_req = 0;
      tick();
      // random requesters
      for (int n = 0; n < 1500; n++) begin
         tick();
         if (hs_if) begin
            if ($urandom_range(1) == 1) if_addr = 10'($urandom); else if_req = 0;
         end else if (!if_req && $urandom_range(2) == 0) begin
            if_req = 1; if_addr = 10'($urandom);
         end
         if (hs_dm) begin
            if ($urandom_range(1) == 1) dm_addr = 10'($urandom); else dm_req = 0;
         end else if (!dm_req && $urandom_range(2) == 0) begin
            dm_req = 1; dm_addr = 10'($urandom);
         end
         if_rready = ($urandom_range(1) == 1);
         dm_rready = ($urandom_range(1) == 1);
      end
      if_rready = 1;
      dm_rready = 1;
      for (int n = 0; n < 40 && (if_req || dm_req || busy); n++) begin
         tick();
         if (hs_if) if_req = 0;
         if (hs_dm) dm_req = 0;
      end
      chk("drain_done", {if_req, dm_req, busy}, 0);
      tick();
      chk("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
